// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target, all CPOL/CPHA modes, MSB-first, valid/ready TX holding register.
// Optional SPI_SLAVE_OVERRUN_EN adds the rx_ack input and the sticky overrun flag.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  overrun
`endif
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
  logic sclk_sync, ss_sync, mosi_sync, sclk_prev, ss_prev, cpol_q, cpha_q;
  logic ss_fall, ss_rise, edge_lead, edge_trail, sample, shift, load, word_done, done_q, tx_full;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, tx_held, rx_shift;
  assign sclk_sync  = sclk_sr[SYNC_STAGES-1];
  assign ss_sync    = ss_sr[SYNC_STAGES-1];
  assign mosi_sync  = mosi_sr[SYNC_STAGES-1];
  assign ss_fall    = ss_prev & ~ss_sync;
  assign ss_rise    = ~ss_prev & ss_sync;
  assign edge_lead  = (sclk_sync != sclk_prev) && (sclk_prev == cpol_q);
  assign edge_trail = (sclk_sync != sclk_prev) && (sclk_sync == cpol_q);
  assign word_done  = sample && (bit_cnt == CW'(DATA_WIDTH - 1));
  assign miso_oe    = (state == ACTIVE);
  assign busy       = (state == ACTIVE);
  assign miso       = miso_oe ? tx_shift[DATA_WIDTH-1] : 1'bz;
  assign tx_ready   = ~tx_full;
  // ss_n rising beats any simultaneous SCLK edge, so a racing sample never lands
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    shift     = 1'b0;
    load      = 1'b0;
    if (state == IDLE) begin
      state_nxt = ss_fall ? ACTIVE : IDLE;
      load      = ss_fall & ~cpha;
    end else if (ss_rise) begin
      state_nxt = IDLE;
    end else begin
      sample = cpha_q ? edge_trail : edge_lead;
      shift  = (cpha_q ? edge_lead : edge_trail) && (bit_cnt != '0);
      load   = (cpha_q ? edge_lead : edge_trail) && (bit_cnt == '0);
    end
  end
  // Synchronizers reset with ss_n low so a select held through reset is not taken as a fresh frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr   <= '0;
      ss_sr     <= '0;
      mosi_sr   <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      ss_sr     <= {ss_sr[SYNC_STAGES-2:0], ss_n};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync;
      ss_prev   <= ss_sync;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      done_q   <= 1'b0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
      tx_held  <= '0;
      tx_full  <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= word_done;
      rx_valid <= done_q;
      if (state == IDLE && ss_fall) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
      if (state == IDLE || ss_rise) bit_cnt <= '0;
      else if (sample) bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      if (sample) rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
      if (word_done) rx_data <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
      tx_shift <= load ? (tx_full ? tx_held : '0) : shift ? {tx_shift[DATA_WIDTH-2:0], 1'b0} : tx_shift;
      if (tx_valid && tx_ready) tx_held <= tx_data;
      tx_full <= (tx_valid && tx_ready) ? 1'b1 : load ? 1'b0 : tx_full;
    end
  end
`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pend, ovr_evt;
  assign ovr_evt = (rx_valid & rx_pend & ~rx_ack) | (load & ~tx_full);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_pend <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_pend <= rx_valid ? 1'b1 : rx_ack ? 1'b0 : rx_pend;
      overrun <= ovr_evt ? 1'b1 : rx_ack ? 1'b0 : overrun;
    end
  end
`endif
endmodule
